// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: per-channel synchroniser followed by a counter-based
// debouncer, producing clean levels, one-cycle edge pulses and a settled flag.
module sw_conditioner #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change,
  output logic             settled
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             change_q;
  logic [WIDTH-1:0] stable_vec;

  // Plain flop chain; nothing may sit between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    clean_d    = clean_q;
    rise_d     = '0;
    fall_d     = '0;
    stable_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      stable_vec[i] = (state_q[i] == STABLE);
      case (state_q[i])
        STABLE: begin
          if (sync[i] != clean_q[i]) begin
            state_d[i] = PENDING;
            cnt_d[i]   = CW'(1);
          end
        end
        PENDING: begin
          // A bounce back to the accepted level abandons qualification.
          if (sync[i] == clean_q[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            clean_d[i] = sync[i];
            rise_d[i]  = sync[i];
            fall_d[i]  = ~sync[i];
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      clean_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= |(rise_d | fall_d);
    end
  end

  assign sw_clean  = clean_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign sw_change = change_q;
  assign settled   = &stable_vec;

endmodule
